// File: rtl/tile_dma_pkg.sv
// Shared constants for the tile-attribute DMA: register map, CTRL bit
// positions and tile geometry common to the video unit and software.
package tile_dma_pkg;

  // Attribute RAM depth in bytes and the visible tile grid it backs
  localparam int TATTR_BYTES   = 512;
  localparam int TILES_X       = 25;
  localparam int TILES_Y       = 19;
  localparam int TILES_VISIBLE = TILES_X * TILES_Y;  // 475

  // Register window offsets
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL bit indices (write: start/abort self-clear, done is write-1-to-clear;
  // read: bit 0 reports busy instead of start)
  localparam int CTRL_START   = 0;
  localparam int CTRL_BUSY    = 0;
  localparam int CTRL_WAIT_VB = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_ABORT   = 3;
  localparam int CTRL_DONE    = 4;

endpackage

// File: rtl/tile_dma_if.sv
// Memory read bus plus attribute RAM write port seen by the DMA engine.
interface tile_dma_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int TA_W       = 9
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;
  logic [7:0]            mem_rdata;
  logic [TA_W-1:0]       tattr_addr;
  logic [7:0]            tattr_wdata;
  logic                  tattr_wenable;

  // DMA engine side
  modport master (
    output mem_req, mem_addr, tattr_addr, tattr_wdata, tattr_wenable,
    input  mem_ready, mem_rdata
  );

  // Memory / video-unit side
  modport slave (
    input  mem_req, mem_addr, tattr_addr, tattr_wdata, tattr_wenable,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/tile_dma.sv
// Tile-attribute copy engine: reads bytes from system memory one at a time
// and writes them into the video unit's attribute RAM, optionally waiting
// for vertical blank before the first read.
module tile_dma
  import tile_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,   // at most 32 (SRC is loaded from reg_wdata)
  parameter int TATTR_SIZE = TATTR_BYTES,
  parameter int LEN_WIDTH  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_wenable,
  output logic [31:0] reg_rdata,
  input  logic        vblank,
  tile_dma_if.master  bus,
  output logic        irq
);

  localparam int TA_W = $clog2(TATTR_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VB, S_READ, S_WRITE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_src, r_cur_src;
  logic [TA_W-1:0]       r_dst, r_cur_dst;
  logic [LEN_WIDTH-1:0]  r_len, r_remaining;
  logic                  r_wait_vb, r_irq_en, r_done;
  logic                  r_abort_pend, r_mem_req, r_twen;
  logic [7:0]            r_data;

  logic w_busy, w_ctrl_wr, w_start, w_abort, w_clr_done, w_cfg_wr;

  assign w_busy     = (r_state != S_IDLE);
  assign w_ctrl_wr  = reg_wenable && (reg_addr == REG_CTRL);
  assign w_start    = w_ctrl_wr && reg_wdata[CTRL_START];
  assign w_abort    = w_ctrl_wr && reg_wdata[CTRL_ABORT];
  assign w_clr_done = w_ctrl_wr && reg_wdata[CTRL_DONE];
  assign w_cfg_wr   = reg_wenable && !w_busy;

  // Programmable registers; transfer parameters are frozen while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_wait_vb <= 1'b0;
      r_irq_en  <= 1'b0;
    end else begin
      if (w_cfg_wr) begin
        case (reg_addr)
          REG_SRC: r_src <= reg_wdata[ADDR_WIDTH-1:0];
          REG_DST: r_dst <= reg_wdata[TA_W-1:0];
          REG_LEN: r_len <= reg_wdata[LEN_WIDTH-1:0];
          default: ;
        endcase
      end
      if (w_ctrl_wr) begin
        r_wait_vb <= reg_wdata[CTRL_WAIT_VB];
        r_irq_en  <= reg_wdata[CTRL_IRQ_EN];
      end
    end
  end

  // Transfer FSM with working counters and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur_src    <= '0;
      r_cur_dst    <= '0;
      r_remaining  <= '0;
      r_done       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_mem_req    <= 1'b0;
      r_twen       <= 1'b0;
      r_data       <= '0;
    end else begin
      r_twen <= 1'b0;
      // Clear first so a start in the same write can re-set done (LEN=0)
      if (w_clr_done) r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (r_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_cur_src    <= r_src;
              r_cur_dst    <= r_dst;
              r_remaining  <= r_len;
              r_abort_pend <= 1'b0;
              // The start write carries the wait_vb bit that is in effect
              if (reg_wdata[CTRL_WAIT_VB]) begin
                r_state <= S_WAIT_VB;
              end else begin
                r_state   <= S_READ;
                r_mem_req <= 1'b1;
              end
            end
          end
        end
        S_WAIT_VB: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (vblank) begin
            r_state   <= S_READ;
            r_mem_req <= 1'b1;
          end
        end
        S_READ: begin
          // A request cannot be withdrawn; remember the abort until ready
          if (w_abort) r_abort_pend <= 1'b1;
          if (bus.mem_ready) begin
            r_mem_req <= 1'b0;
            if (r_abort_pend || w_abort) begin
              r_state      <= S_IDLE;
              r_abort_pend <= 1'b0;
            end else begin
              r_data  <= bus.mem_rdata;
              r_state <= S_WRITE;
              r_twen  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_cur_src   <= r_cur_src + ADDR_WIDTH'(1);
          r_cur_dst   <= r_cur_dst + TA_W'(1);
          r_remaining <= r_remaining - LEN_WIDTH'(1);
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (r_remaining == LEN_WIDTH'(1)) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state   <= S_READ;
            r_mem_req <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req       = r_mem_req;
  assign bus.mem_addr      = r_cur_src;
  assign bus.tattr_addr    = r_cur_dst;
  assign bus.tattr_wdata   = r_data;
  assign bus.tattr_wenable = r_twen;
  assign irq               = r_done & r_irq_en;

  // Register read mux
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_SRC: reg_rdata = 32'(r_src);
      REG_DST: reg_rdata = 32'(r_dst);
      REG_LEN: reg_rdata = 32'(r_len);
      default: begin
        reg_rdata[CTRL_BUSY]    = w_busy;
        reg_rdata[CTRL_WAIT_VB] = r_wait_vb;
        reg_rdata[CTRL_IRQ_EN]  = r_irq_en;
        reg_rdata[CTRL_DONE]    = r_done;
      end
    endcase
  end

endmodule

// File: tb/tb_tile_dma.sv
// Directed bench for tile_dma: memory responder with programmable latency,
// attribute-write logger, and a linear sequence of checked scenarios.
module tb_tile_dma;
  import tile_dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] reg_wdata = 32'd0;
  logic        reg_wenable = 1'b0;
  logic [31:0] reg_rdata;
  logic        vblank = 1'b0;
  logic        irq;

  tile_dma_if #(.ADDR_WIDTH(32), .TA_W(9)) bus ();

  tile_dma #(.ADDR_WIDTH(32), .TATTR_SIZE(512), .LEN_WIDTH(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wenable (reg_wenable),
    .reg_rdata   (reg_rdata),
    .vblank      (vblank),
    .bus         (bus),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: byte at address a is a[7:0] + 0xA0
  int          mem_delay = 0;
  int          wcnt = 0;
  int          req_cycles = 0;
  int          stab_viol = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  int          wr_cyc[$];
  logic [8:0]  wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [31:0] rd_addr[$];

  // Responder answers first, then the logger records what the DUT drives
  always @(negedge clk) begin
    if (rst_n && bus.mem_req) begin
      req_cycles++;
      if (prev_wait && bus.mem_addr !== prev_addr) stab_viol++;
      if (wcnt >= mem_delay) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = bus.mem_addr[7:0] + 8'hA0;
        rd_addr.push_back(bus.mem_addr);
        wcnt = 0;
        prev_wait = 1'b0;
      end else begin
        bus.mem_ready = 1'b0;
        wcnt++;
        prev_wait = 1'b1;
      end
      prev_addr = bus.mem_addr;
    end else begin
      bus.mem_ready = 1'b0;
      wcnt = 0;
      prev_wait = 1'b0;
    end
    if (bus.tattr_wenable === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(bus.tattr_addr);
      wr_data.push_back(bus.tattr_wdata);
      $display("tattr write cyc=%0d addr=%0d data=0x%02h", cyc, bus.tattr_addr, bus.tattr_wdata);
    end
  end

  int nchecks = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_addr    = a;
    reg_wdata   = d;
    reg_wenable = 1'b1;
    tick();
    reg_wenable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic clear_log();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    rd_addr.delete();
    req_cycles = 0;
    stab_viol  = 0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    logic [31:0] v;
    int k;
    k = 0;
    rd(REG_CTRL, v);
    while (v[CTRL_BUSY] === 1'b1 && k < max) begin
      tick();
      rd(REG_CTRL, v);
      k++;
    end
    chk(tag, {31'd0, v[CTRL_BUSY]}, 32'd0);
  endtask

  // Compare logged writes against consecutive addresses/data from a base
  task automatic chk_writes(input string tag, input int cnt, input int dst0, input int data0);
    chk({tag, "_nwr"}, wr_addr.size(), cnt);
    for (int i = 0; i < cnt && i < wr_addr.size(); i++) begin
      chk({tag, "_waddr"}, wr_addr[i], (dst0 + i) % 512);
      chk({tag, "_wdata"}, wr_data[i], (data0 + i) & 8'hFF);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ---- reset ----
    repeat (3) tick();
    chk("rst_mem_req", bus.mem_req, 0);
    rst_n = 1'b1;
    tick();
    chk_reg("rst_src", REG_SRC, 0);
    chk_reg("rst_dst", REG_DST, 0);
    chk_reg("rst_len", REG_LEN, 0);
    chk_reg("rst_ctrl", REG_CTRL, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_twen", bus.tattr_wenable, 0);
    chk("rst_irq", irq, 0);

    // ---- basic copy, zero-wait memory ----
    clear_log();
    wr(REG_SRC, 32'h100);
    wr(REG_DST, 32'd0);
    wr(REG_LEN, 32'd4);
    n = cyc;
    wr(REG_CTRL, 32'h1);
    chk_reg("t1_busy", REG_CTRL, 32'h1);
    chk("t1_req", bus.mem_req, 1);
    chk("t1_maddr", bus.mem_addr, 32'h100);
    wait_idle("t1_idle", 40);
    chk_writes("t1", 4, 0, 'hA0);
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++) chk("t1_wcyc", wr_cyc[i], n + 2 + 2 * i);
    chk_reg("t1_done", REG_CTRL, 32'h10);
    wr(REG_CTRL, 32'h10);
    chk_reg("t1_clr", REG_CTRL, 32'h0);

    // ---- destination wrap (DST written with an out-of-range value) ----
    clear_log();
    wr(REG_SRC, 32'h2000);
    wr(REG_DST, 32'h3FE);
    chk_reg("t2_dst_trunc", REG_DST, 32'h1FE);
    wr(REG_LEN, 32'd4);
    wr(REG_CTRL, 32'h1);
    wait_idle("t2_idle", 40);
    chk_writes("t2", 4, 510, 'hA0);
    chk("t2_nrd", rd_addr.size(), 4);
    for (int i = 0; i < 4 && i < rd_addr.size(); i++) chk("t2_raddr", rd_addr[i], 32'h2000 + i);
    wr(REG_CTRL, 32'h10);

    // ---- vblank gating ----
    clear_log();
    vblank = 1'b0;
    wr(REG_SRC, 32'h300);
    wr(REG_DST, 32'd5);
    wr(REG_LEN, 32'd2);
    wr(REG_CTRL, 32'h2);
    wr(REG_CTRL, 32'h3);
    repeat (49) tick();
    chk("t3_noreq", req_cycles, 0);
    chk_reg("t3_waiting", REG_CTRL, 32'h3);
    vblank = 1'b1;
    chk("t3_req_lo", bus.mem_req, 0);
    tick();
    chk("t3_req_hi", bus.mem_req, 1);
    vblank = 1'b0;
    wait_idle("t3_idle", 40);
    chk_writes("t3", 2, 5, 'hA0);
    wr(REG_CTRL, 32'h10);
    chk_reg("t3_clr", REG_CTRL, 32'h0);

    // ---- backpressure: 3 wait cycles per byte ----
    clear_log();
    mem_delay = 3;
    wr(REG_SRC, 32'h400);
    wr(REG_DST, 32'd100);
    wr(REG_LEN, 32'd3);
    wr(REG_CTRL, 32'h1);
    wait_idle("t4_idle", 100);
    chk_writes("t4", 3, 100, 'hA0);
    chk("t4_reqcyc", req_cycles, 12);
    chk("t4_stable", stab_viol, 0);
    wr(REG_CTRL, 32'h10);

    // ---- abort while a read is outstanding ----
    clear_log();
    mem_delay = 2;
    wr(REG_SRC, 32'h500);
    wr(REG_DST, 32'd7);
    wr(REG_LEN, 32'd3);
    wr(REG_CTRL, 32'h1);
    chk("t5_req", bus.mem_req, 1);
    wr(REG_CTRL, 32'h8);
    chk("t5_req_held1", bus.mem_req, 1);
    chk("t5_maddr", bus.mem_addr, 32'h500);
    tick();
    chk("t5_req_held2", bus.mem_req, 1);
    tick();
    chk_reg("t5_idle", REG_CTRL, 32'h0);
    chk("t5_req_off", bus.mem_req, 0);
    repeat (5) tick();
    chk("t5_nwr", wr_addr.size(), 0);
    chk("t5_nrd", rd_addr.size(), 1);
    chk_reg("t5_nodone", REG_CTRL, 32'h0);
    mem_delay = 0;

    // ---- LEN=0 start with interrupt enabled ----
    clear_log();
    wr(REG_LEN, 32'd0);
    wr(REG_CTRL, 32'h5);
    chk_reg("t6_done", REG_CTRL, 32'h14);
    chk("t6_irq", irq, 1);
    chk("t6_noreq0", bus.mem_req, 0);
    repeat (3) tick();
    chk("t6_noreq", req_cycles, 0);
    wr(REG_CTRL, 32'h14);
    chk("t6_irq_clr", irq, 0);
    chk_reg("t6_ctrl", REG_CTRL, 32'h4);

    // ---- start together with done-clear; config writes ignored while busy ----
    clear_log();
    wr(REG_CTRL, 32'h1);
    chk_reg("t7_done_pre", REG_CTRL, 32'h10);
    wr(REG_SRC, 32'h600);
    wr(REG_DST, 32'h20);
    wr(REG_LEN, 32'd2);
    wr(REG_CTRL, 32'h11);
    chk_reg("t7_busy_nodone", REG_CTRL, 32'h1);
    wr(REG_LEN, 32'd7);
    chk_reg("t7_len_locked", REG_LEN, 32'd2);
    wait_idle("t7_idle", 40);
    chk_writes("t7", 2, 'h20, 'hA0);
    chk_reg("t7_done", REG_CTRL, 32'h10);

    // ---- asynchronous reset mid-transfer ----
    clear_log();
    mem_delay = 3;
    wr(REG_SRC, 32'h700);
    wr(REG_LEN, 32'd4);
    wr(REG_CTRL, 32'h1);
    tick();
    chk("t8_req_pre", bus.mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t8_req_drop", bus.mem_req, 0);
    chk_reg("t8_ctrl", REG_CTRL, 32'h0);
    chk_reg("t8_src", REG_SRC, 32'h0);
    tick();
    rst_n = 1'b1;
    mem_delay = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
